// File: rtl/hls_ap_bus_mem_responder_if.sv
// rtl/hls_ap_bus_mem_responder_if.sv - ap_bus core port and backend memory port bundle
interface hls_ap_bus_mem_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    logic                  mem0_V_req_write;
    logic                  mem0_V_req_din;
    logic                  mem0_V_req_full_n;
    logic [ADDR_WIDTH-1:0] mem0_V_address;
    logic [ADDR_WIDTH-1:0] mem0_V_size;
    logic [DATA_WIDTH-1:0] mem0_V_dataout;
    logic [DATA_WIDTH-1:0] mem0_V_datain;
    logic                  mem0_V_rsp_empty_n;
    logic                  mem0_V_rsp_read;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    logic                  busy;

    modport master (
        output mem0_V_req_write, mem0_V_req_din, mem0_V_address, mem0_V_size,
               mem0_V_dataout, mem0_V_rsp_read, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  mem0_V_req_full_n, mem0_V_datain, mem0_V_rsp_empty_n, mem_req_valid,
               mem_req_write, mem_req_addr, mem_req_wdata, busy
    );

    modport slave (
        input  mem0_V_req_write, mem0_V_req_din, mem0_V_address, mem0_V_size,
               mem0_V_dataout, mem0_V_rsp_read, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output mem0_V_req_full_n, mem0_V_datain, mem0_V_rsp_empty_n, mem_req_valid,
               mem_req_write, mem_req_addr, mem_req_wdata, busy
    );
endinterface

// File: rtl/hls_ap_bus_mem_responder.sv
// rtl/hls_ap_bus_mem_responder.sv - ap_bus burst responder bridging to a simple memory backend
// Reads are credit-gated into a FWFT response FIFO; writes pass through a one-entry holding register.
module hls_ap_bus_mem_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    hls_ap_bus_mem_responder_if.slave        bus
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_DATA} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]         out_q, out_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

    logic          full_n, beat, rd_issue, rd_fire, req_fire, push, pop;
    logic [CW:0]   credit_used;

    always_comb begin
        credit_used = {1'b0, out_q} + {1'b0, cnt_q};
        // ap_rst gates full_n so it reads 0 for the whole reset window
        full_n   = !ap_rst && !hold_vld_q && (state_q != RD_ISSUE);
        beat     = bus.mem0_V_req_write && full_n;
        rd_issue = (state_q == RD_ISSUE) && !hold_vld_q && (credit_used < (CW+1)'(RSP_DEPTH));
        rd_fire  = rd_issue && bus.mem_req_ready;
        req_fire = (hold_vld_q || rd_issue) && bus.mem_req_ready;
        // responses with nothing outstanding belong to a burst killed by reset
        push     = bus.mem_rsp_valid && (out_q != '0);
        pop      = bus.mem0_V_rsp_read && (cnt_q != '0);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (req_fire) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (hold_vld_q) begin
                hold_vld_d = 1'b0;
            end else begin
                rem_d = rem_q - ADDR_WIDTH'(1);
                if (rem_q == ADDR_WIDTH'(1)) state_d = IDLE;
            end
        end

        case (state_q)
            IDLE: begin
                if (beat) begin
                    addr_d = bus.mem0_V_address;
                    rem_d  = bus.mem0_V_size;
                    if (bus.mem0_V_size != '0) begin
                        if (bus.mem0_V_req_din) begin
                            hold_vld_d  = 1'b1;
                            hold_data_d = bus.mem0_V_dataout;
                            rem_d       = bus.mem0_V_size - ADDR_WIDTH'(1);
                            if (bus.mem0_V_size != ADDR_WIDTH'(1)) state_d = WR_DATA;
                        end else begin
                            state_d = RD_ISSUE;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (beat) begin
                    hold_vld_d  = 1'b1;
                    hold_data_d = bus.mem0_V_dataout;
                    rem_d       = rem_q - ADDR_WIDTH'(1);
                    if (rem_q == ADDR_WIDTH'(1)) state_d = IDLE;
                end
            end
            default: ;
        endcase

        case ({rd_fire, push})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) fifo_q[wr_ptr_q] <= bus.mem_rsp_data;
    end

    assign bus.mem0_V_req_full_n  = full_n;
    assign bus.mem0_V_rsp_empty_n = (cnt_q != '0);
    assign bus.mem0_V_datain      = (cnt_q != '0) ? fifo_q[rd_ptr_q] : '0;
    assign bus.mem_req_valid      = hold_vld_q || rd_issue;
    assign bus.mem_req_write      = hold_vld_q;
    assign bus.mem_req_addr       = addr_q;
    assign bus.mem_req_wdata      = hold_data_q;
    assign bus.busy               = (state_q != IDLE) || (out_q != '0) || (cnt_q != '0);
endmodule

// File: tb/tb_hls_ap_bus_mem_responder.sv
// tb/tb_hls_ap_bus_mem_responder.sv - self-checking bench for hls_ap_bus_mem_responder
module tb_hls_ap_bus_mem_responder;
    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct packed {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    hls_ap_bus_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    hls_ap_bus_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ready_mode, pop_mode, lat_min, lat_max;
    int n_rd, n_pop, last_due;
    req_t exp_req [$];
    logic [DW-1:0] exp_pop [$];
    rsp_t rsp_q [$];
    int req_cyc [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
        return {a ^ 32'hC0DE_0000, ~a ^ 32'h0000_5A5A};
    endfunction

    task automatic record_req();
        req_t e;
        rsp_t r;
        int   due;
        req_cyc.push_back(cyc);
        if (exp_req.size() == 0) begin
            check("unexpected_req", 64'd1, 64'd0);
            return;
        end
        e = exp_req.pop_front();
        check("req_write", 64'(bus.mem_req_write), 64'(e.wr));
        check("req_addr", 64'(bus.mem_req_addr), 64'(e.addr));
        if (e.wr) begin
            check("req_wdata", bus.mem_req_wdata, e.data);
        end else begin
            check("credit", 64'((n_rd - n_pop) < DEPTH), 64'd1);
            n_rd++;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due  = due;
            r.data = rd_data(bus.mem_req_addr);
            rsp_q.push_back(r);
        end
    endtask

    task automatic record_pop();
        if (exp_pop.size() == 0) begin
            check("unexpected_pop", 64'd1, 64'd0);
            return;
        end
        check("datain", bus.mem0_V_datain, exp_pop.pop_front());
        n_pop++;
    endtask

    // One clock: log handshakes that the coming edge will complete, then drive the next inputs
    task automatic tick();
        if (bus.mem_req_valid && bus.mem_req_ready) record_req();
        if (bus.mem0_V_rsp_empty_n && bus.mem0_V_rsp_read) record_pop();
        @(posedge ap_clk);
        @(negedge ap_clk);
        cyc++;
        case (ready_mode)
            0:       bus.mem_req_ready = 1'b0;
            1:       bus.mem_req_ready = 1'b1;
            default: bus.mem_req_ready = ($urandom_range(3) != 0);
        endcase
        case (pop_mode)
            0:       bus.mem0_V_rsp_read = 1'b0;
            1:       bus.mem0_V_rsp_read = 1'b1;
            default: bus.mem0_V_rsp_read = ($urandom_range(3) != 0);
        endcase
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = {$urandom, $urandom};
        end
    endtask

    task automatic send_beat(input logic din, input logic [AW-1:0] a, input logic [AW-1:0] sz,
                             input logic [DW-1:0] d, output int acc_cyc);
        int n;
        n = 0;
        bus.mem0_V_req_write = 1'b1;
        bus.mem0_V_req_din   = din;
        bus.mem0_V_address   = a;
        bus.mem0_V_size      = sz;
        bus.mem0_V_dataout   = d;
        while (!bus.mem0_V_req_full_n && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            check("beat_timeout", 64'd0, 64'd1);
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc;
            tick();
        end
        bus.mem0_V_req_write = 1'b0;
        bus.mem0_V_req_din   = 1'($urandom);
        bus.mem0_V_address   = $urandom;
        bus.mem0_V_size      = $urandom;
        bus.mem0_V_dataout   = {$urandom, $urandom};
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int sz, output int acc_cyc);
        req_t e;
        for (int i = 0; i < sz; i++) begin
            e.wr   = 1'b0;
            e.addr = a + AW'(i);
            e.data = '0;
            exp_req.push_back(e);
            exp_pop.push_back(rd_data(e.addr));
        end
        send_beat(1'b0, a, AW'(sz), {$urandom, $urandom}, acc_cyc);
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int sz);
        req_t e;
        int   acc;
        if (sz == 0) begin
            send_beat(1'b1, a, '0, {$urandom, $urandom}, acc);
            return;
        end
        for (int i = 0; i < sz; i++) begin
            e.wr   = 1'b1;
            e.addr = a + AW'(i);
            e.data = {$urandom, $urandom};
            exp_req.push_back(e);
            if (i == 0) send_beat(1'b1, a, AW'(sz), e.data, acc);
            else        send_beat(1'($urandom), $urandom, $urandom, e.data, acc);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_req.size() != 0 || exp_pop.size() != 0 || rsp_q.size() != 0 || bus.busy)
               && n < 3000) begin
            tick();
            n++;
        end
        check("drain_done", 64'(n < 3000), 64'd1);
    endtask

    initial begin
        int acc, base, n;
        logic [AW-1:0] a;

        bus.mem0_V_req_write = 1'b0;
        bus.mem0_V_req_din   = 1'b0;
        bus.mem0_V_address   = '0;
        bus.mem0_V_size      = '0;
        bus.mem0_V_dataout   = '0;
        bus.mem0_V_rsp_read  = 1'b0;
        bus.mem_req_ready    = 1'b0;
        bus.mem_rsp_valid    = 1'b0;
        bus.mem_rsp_data     = '0;
        ready_mode = 1; pop_mode = 1; lat_min = 2; lat_max = 2;
        n_rd = 0; n_pop = 0; last_due = 0;

        #2;
        check("rst_full_n", 64'(bus.mem0_V_req_full_n), 64'd0);
        check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_empty_n", 64'(bus.mem0_V_rsp_empty_n), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_datain", bus.mem0_V_datain, 64'd0);
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        tick();
        check("post_rst_full_n", 64'(bus.mem0_V_req_full_n), 64'd1);

        // read burst: consecutive issue, in-order data, idle after last pop
        req_cyc.delete();
        read_burst(32'h100, 3, acc);
        n = 0;
        while (exp_pop.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("rd_pops_done", 64'(exp_pop.size()), 64'd0);
        check("rd_busy_after_pop", 64'(bus.busy), 64'd0);
        check("rd_req_count", 64'(req_cyc.size()), 64'd3);
        if (req_cyc.size() == 3) begin
            check("rd_first_issue", 64'(req_cyc[0]), 64'(acc + 1));
            check("rd_second_issue", 64'(req_cyc[1]), 64'(acc + 2));
            check("rd_third_issue", 64'(req_cyc[2]), 64'(acc + 3));
        end

        // credit limiting with no pops
        pop_mode = 0;
        bus.mem0_V_rsp_read = 1'b0;
        base = n_rd;
        read_burst(32'h300, 6, acc);
        repeat (12) tick();
        check("credit_hold_four", 64'(n_rd - base), 64'd4);
        bus.mem0_V_rsp_read = 1'b1;
        tick();
        repeat (8) tick();
        check("credit_fifth_after_pop", 64'(n_rd - base), 64'd5);
        pop_mode = 1;
        drain();

        // write burst: one-cycle backend latency, full_n low while held
        req_t_block: begin
            req_t e;
            e.wr = 1'b1; e.addr = 32'h20; e.data = 64'hA;
            exp_req.push_back(e);
            e.addr = 32'h21; e.data = 64'hB;
            exp_req.push_back(e);
        end
        send_beat(1'b1, 32'h20, 32'd2, 64'hA, acc);
        check("wr_full_n_beat0", 64'(bus.mem0_V_req_full_n), 64'd0);
        check("wr_valid_lat1", 64'(bus.mem_req_valid), 64'd1);
        send_beat(1'b0, 32'h777, 32'd9, 64'hB, acc);
        check("wr_full_n_beat1", 64'(bus.mem0_V_req_full_n), 64'd0);
        drain();

        // backpressure with address wrap
        ready_mode = 0;
        bus.mem_req_ready = 1'b0;
        read_burst(32'hFFFF_FFFF, 2, acc);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(bus.mem_req_valid), 64'd1);
            check("stall_addr", 64'(bus.mem_req_addr), 64'hFFFF_FFFF);
            tick();
        end
        ready_mode = 1;
        bus.mem_req_ready = 1'b1;
        drain();

        // size-0 bursts are swallowed
        send_beat(1'b0, 32'h55, 32'd0, 64'h1, acc);
        check("size0_rd_accept", 64'(acc >= 0), 64'd1);
        repeat (4) begin
            check("size0_rd_no_req", 64'(bus.mem_req_valid), 64'd0);
            check("size0_rd_idle", 64'(bus.busy), 64'd0);
            tick();
        end
        send_beat(1'b1, 32'h66, 32'd0, 64'h2, acc);
        check("size0_wr_accept", 64'(acc >= 0), 64'd1);
        repeat (4) begin
            check("size0_wr_no_req", 64'(bus.mem_req_valid), 64'd0);
            check("size0_wr_idle", 64'(bus.busy), 64'd0);
            tick();
        end

        // reset while the second backend read is presented
        lat_min = 3; lat_max = 3;
        base = n_rd;
        read_burst(32'h400, 4, acc);
        n = 0;
        while ((n_rd - base) < 1 && n < 50) begin
            tick();
            n++;
        end
        check("mid_first_read", 64'(n_rd - base), 64'd1);
        ap_rst = 1'b1;
        #1;
        check("mid_rst_full_n", 64'(bus.mem0_V_req_full_n), 64'd0);
        check("mid_rst_valid", 64'(bus.mem_req_valid), 64'd0);
        check("mid_rst_addr", 64'(bus.mem_req_addr), 64'd0);
        check("mid_rst_empty_n", 64'(bus.mem0_V_rsp_empty_n), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        exp_req.delete();
        exp_pop.delete();
        n_rd = 0; n_pop = 0;
        tick();
        tick();
        ap_rst = 1'b0;
        tick();
        check("mid_release_full_n", 64'(bus.mem0_V_req_full_n), 64'd1);
        repeat (6) begin
            check("mid_stale_empty_n", 64'(bus.mem0_V_rsp_empty_n), 64'd0);
            check("mid_stale_datain", bus.mem0_V_datain, 64'd0);
            tick();
        end
        drain();

        // randomized mixed traffic against the scoreboard
        ready_mode = 2; pop_mode = 2; lat_min = 1; lat_max = 3;
        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - AW'($urandom_range(3))) : $urandom;
            if ($urandom_range(1) == 0) read_burst(a, $urandom_range(5), acc);
            else                        write_burst(a, $urandom_range(5));
            repeat ($urandom_range(2)) tick();
        end
        pop_mode = 1;
        drain();
        check("final_rsp_queue", 64'(rsp_q.size()), 64'd0);
        check("final_busy", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
